crc_serial_gen: RTL and testbench
=================================

CRC_SERIAL_GEN -- requirements
Module: crc_serial_gen

Interface
REQ-001 The block SHALL have parameter CRC_WIDTH, default 8: LFSR/CRC width, legal range 2..32.
REQ-002 The block SHALL have parameter POLY, default 8'h44, CRC_WIDTH bits: tap mask, where bit i (i < CRC_WIDTH-1) XORs feedback into next[i]; bit CRC_WIDTH-1 is ignored.
REQ-003 The block SHALL have parameter SEED, default 8'hD8, CRC_WIDTH bits: LFSR value loaded at the start of each frame.
REQ-004 The block SHALL have port clk, input, 1 bit: single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: asynchronous, active-high reset.
REQ-006 The block SHALL have port data_in, input, 1 bit: serial message bit, LSB first.
REQ-007 The block SHALL have port data_valid, input, 1 bit: data_in qualifier; a contiguous high run forms one frame.
REQ-008 The block SHALL have port crc_out, output, 1 bit: serial CRC bit, LSB first, registered.
REQ-009 The block SHALL have port crc_valid, output, 1 bit: crc_out qualifier, registered.
REQ-010 The block SHALL have port done_tick, output, 1 bit: one-cycle end-of-frame pulse, registered.
REQ-011 The block SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-012 The block SHALL implement a four-state FSM with states IDLE, CALC, OUT and DONE.
REQ-013 The block SHALL define one LFSR step as: fb = data_in ^ lfsr[0]; next[CRC_WIDTH-1] = fb; next[i] = lfsr[i+1] ^ (POLY[i] & fb) for i < CRC_WIDTH-1.
REQ-014 In IDLE with data_valid=1, the block SHALL set lfsr <= step(SEED, data_in) and go to CALC (the first bit is not lost); with data_valid=0 it SHALL remain in IDLE.
REQ-015 In CALC with data_valid=1, the block SHALL set lfsr <= step(lfsr, data_in); with data_valid=0, it SHALL go to OUT, clear the bit counter, and ignore data_in.
REQ-016 In OUT, each edge SHALL set crc_out <= lfsr[0], crc_valid <= 1, lfsr <= lfsr >> 1 and count <= count+1; when count == CRC_WIDTH-1 at that edge, the FSM SHALL go to DONE.
REQ-017 In DONE, one edge SHALL set crc_valid <= 0, crc_out <= 0 and done_tick <= 1, and return to IDLE; on the following edge done_tick SHALL return to 0.
REQ-018 Latency: with data_valid sampled low at edge k, crc_valid SHALL be high for edges k+1..k+CRC_WIDTH, and done_tick SHALL be high after edge k+CRC_WIDTH+1.
REQ-019 data_valid SHALL be ignored in OUT and DONE; a new frame SHALL be accepted only from IDLE, with a minimum gap of 1 cycle after DONE.
REQ-020 A one-bit frame (data_valid high for 1 cycle) SHALL be legal and produce a full CRC_WIDTH-bit output.
REQ-021 The bit counter width SHALL be $clog2(CRC_WIDTH), and the counter SHALL never wrap within a frame.
REQ-022 There SHALL be no limit on frame length; the LFSR simply keeps stepping.

Reset
REQ-023 rst=1 SHALL immediately force state=IDLE, lfsr=SEED, count=0, crc_out=0, crc_valid=0, done_tick=0 and busy=0, independent of clk.
REQ-024 Reset asserted mid-frame (CALC/OUT/DONE) SHALL abort the frame with no done_tick, and the next frame SHALL start from SEED.
REQ-025 After rst deasserts, the first rising edge SHALL already be able to accept data_valid.

Verification
REQ-026 Defaults, 8 frame bits all 0 -> lfsr=0x14; crc_out sequence 0,0,1,0,1,0,0,0 over 8 cycles with crc_valid high; then done_tick for 1 cycle.
REQ-027 Defaults, 1-bit frame data_in=1 -> crc_out sequence 0,0,0,1,0,1,0,1; done_tick 9 cycles after data_valid falls.
REQ-028 data_valid held high through OUT/DONE with random data_in -> CRC output is unchanged from the REQ-026 result; a new frame starts only after IDLE.
REQ-029 rst pulsed (2 ns, mid-cycle) during the 4th OUT bit -> outputs go to 0 immediately, no done_tick; the next frame of 8 zeros again yields 0x14.
REQ-030 Back-to-back frames with a 1-cycle gap -> both CRCs are correct; busy drops for exactly 1 cycle between frames.
REQ-031 Parameter sweep CRC_WIDTH=16, POLY=16'h1021 (reflected-LSB model), SEED=16'hFFFF, 64 random frames -> every frame matches the bench reference model bit-for-bit; crc_valid is high for exactly 16 cycles per frame.

Source files
------------

// File: rtl/crc_serial_gen.sv
// crc_serial_gen: bit-serial LFSR CRC generator that streams the CRC out LSB first after each frame.
module crc_serial_gen #(
  parameter int                   CRC_WIDTH = 8,
  parameter logic [CRC_WIDTH-1:0] POLY      = CRC_WIDTH'('h44),
  parameter logic [CRC_WIDTH-1:0] SEED      = CRC_WIDTH'('hD8)
) (
  input  logic clk,
  input  logic rst,
  input  logic data_in,
  input  logic data_valid,
  output logic crc_out,
  output logic crc_valid,
  output logic done_tick,
  output logic busy
);
  localparam int CW = $clog2(CRC_WIDTH);
  localparam logic [CW-1:0] LAST = CW'(CRC_WIDTH - 1);
  typedef enum logic [1:0] {IDLE, CALC, OUT, DONE} state_t;
  state_t               state;
  logic [CRC_WIDTH-1:0] lfsr;
  logic [CW-1:0]        count;
  function automatic logic [CRC_WIDTH-1:0] step(input logic [CRC_WIDTH-1:0] l, input logic d);
    logic fb;
    fb = d ^ l[0];
    return {fb, l[CRC_WIDTH-1:1] ^ (POLY[CRC_WIDTH-2:0] & {(CRC_WIDTH-1){fb}})};
  endfunction
  assign busy = state != IDLE;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      lfsr      <= SEED;
      count     <= '0;
      crc_out   <= 1'b0;
      crc_valid <= 1'b0;
      done_tick <= 1'b0;
    end else begin
      done_tick <= 1'b0;
      case (state)
        IDLE: if (data_valid) begin
          lfsr  <= step(SEED, data_in);
          state <= CALC;
        end
        CALC: if (data_valid) lfsr <= step(lfsr, data_in);
        else begin
          state <= OUT;
          count <= '0;
        end
        OUT: begin
          crc_out   <= lfsr[0];
          crc_valid <= 1'b1;
          lfsr      <= lfsr >> 1;
          // clear on the last bit so the counter never wraps
          count     <= (count == LAST) ? '0 : count + CW'(1);
          if (count == LAST) state <= DONE;
        end
        DONE: begin
          crc_valid <= 1'b0;
          crc_out   <= 1'b0;
          done_tick <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_serial_gen.sv
// tb_crc_serial_gen: directed and random frames on an 8-bit default and a 16-bit instance,
// checked against a reflected shift-register CRC reference.
module tb_crc_serial_gen;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] di = '0, dv = '0;
  logic [1:0] co, cv, dt, bz;
  int checks = 0, failures = 0;
  bit q[$];

  always #5 clk = ~clk;

  crc_serial_gen u8 (
    .clk(clk), .rst(rst), .data_in(di[0]), .data_valid(dv[0]),
    .crc_out(co[0]), .crc_valid(cv[0]), .done_tick(dt[0]), .busy(bz[0])
  );
  crc_serial_gen #(.CRC_WIDTH(16), .POLY(16'h1021), .SEED(16'hFFFF)) u16 (
    .clk(clk), .rst(rst), .data_in(di[1]), .data_valid(dv[1]),
    .crc_out(co[1]), .crc_valid(cv[1]), .done_tick(dt[1]), .busy(bz[1])
  );

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    checks++;
    assert (o === e) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  // Reflected CRC: shift right, xor the tap mask (with the top bit forced) when lsb^data is 1.
  function automatic int model(input int s, input bit b[$]);
    int w, m, c;
    w = s ? 16 : 8;
    m = s ? 'h1021 : 'h44;
    c = s ? 'hFFFF : 'hD8;
    m = (m & ((1 << (w - 1)) - 1)) | (1 << (w - 1));
    foreach (b[i]) c = ((c ^ int'(b[i])) & 1) ? ((c >> 1) ^ m) : (c >> 1);
    return c;
  endfunction

  task automatic frame(input int s, input bit b[$], input bit hold, input bit chain, input int expv);
    int w, e;
    w = s ? 16 : 8;
    e = (expv < 0) ? model(s, b) : expv;
    foreach (b[i]) begin
      dv[s] = 1'b1;
      di[s] = b[i];
      @(negedge clk);
      chk("busy_calc", 32'(bz[s]), 1);
    end
    dv[s] = 1'b0;
    di[s] = 1'($urandom);
    @(negedge clk);
    chk("cv_pre", 32'(cv[s]), 0);
    dv[s] = hold;
    for (int i = 0; i < w; i++) begin
      if (hold) di[s] = 1'($urandom);
      @(negedge clk);
      chk("cv_on", 32'(cv[s]), 1);
      chk("crc_bit", 32'(co[s]), 32'((e >> i) & 1));
      chk("busy_out", 32'(bz[s]), 1);
    end
    @(negedge clk);
    chk("cv_end", 32'(cv[s]), 0);
    chk("done_tick", 32'(dt[s]), 1);
    chk("co_zero", 32'(co[s]), 0);
    chk("busy_gap", 32'(bz[s]), 0);
    dv[s] = 1'b0;
    if (!chain) begin
      @(negedge clk);
      chk("done_clr", 32'(dt[s]), 0);
      chk("busy_idle", 32'(bz[s]), 0);
    end
  endtask

  initial begin
    #1;
    for (int s = 0; s < 2; s++) begin
      chk("rst_cv", 32'(cv[s]), 0);
      chk("rst_co", 32'(co[s]), 0);
      chk("rst_dt", 32'(dt[s]), 0);
      chk("rst_busy", 32'(bz[s]), 0);
    end
    @(negedge clk);
    rst = 1'b0;
    q = {};
    repeat (8) q.push_back(1'b0);
    frame(0, q, 1'b0, 1'b0, 'h14);
    q = {1'b1};
    frame(0, q, 1'b0, 1'b0, 'hA8);
    q = {};
    repeat (8) q.push_back(1'b0);
    frame(0, q, 1'b1, 1'b0, 'h14);
    foreach (q[i]) begin
      dv[0] = 1'b1;
      di[0] = 1'b0;
      @(negedge clk);
    end
    dv[0] = 1'b0;
    @(negedge clk);
    repeat (3) @(negedge clk);
    chk("rst_pre_cv", 32'(cv[0]), 1);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("rst_mid_cv", 32'(cv[0]), 0);
    chk("rst_mid_co", 32'(co[0]), 0);
    chk("rst_mid_busy", 32'(bz[0]), 0);
    chk("rst_mid_dt", 32'(dt[0]), 0);
    #1 rst = 1'b0;
    repeat (12) begin
      @(negedge clk);
      chk("rst_no_done", 32'(dt[0]), 0);
    end
    frame(0, q, 1'b0, 1'b1, 'h14);
    q = {};
    repeat (5) q.push_back(1'($urandom));
    frame(0, q, 1'b0, 1'b0, -1);
    for (int f = 0; f < 20; f++) begin
      q = {};
      repeat ($urandom_range(1, 24)) q.push_back(1'($urandom));
      frame(0, q, 1'($urandom), 1'($urandom), -1);
    end
    for (int f = 0; f < 64; f++) begin
      q = {};
      repeat ($urandom_range(1, 40)) q.push_back(1'($urandom));
      frame(1, q, 1'($urandom), f[0], -1);
    end
    repeat (2) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
